// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: word FIFO that splits 1/2/4-byte store entries into a byte stream
// for the UART transmitter. Define UART_TX_BUFFER_BIG_ENDIAN_EN to send MSB first.
module uart_tx_buffer #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_nbytes,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        ovf,
  output logic        busy,
  output logic [7:0]  send_data,
  output logic        Sdata_valid,
  input  logic        Send_fin
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  typedef struct packed {
    logic [1:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    send_data_q, send_data_d;
  logic          sdata_valid_q;
  logic [1:0]    nb_norm;
  entry_t        head;
  logic          push, pop;

  // Byte k of the head entry, in transmit order.
  function automatic logic [7:0] pick_byte(entry_t e, logic [1:0] k);
    logic [1:0] sel;
`ifdef UART_TX_BUFFER_BIG_ENDIAN_EN
    sel = e.nbytes - k;
`else
    sel = k;
`endif
    return e.data[{sel, 3'b000} +: 8];
  endfunction

  assign nb_norm = (wr_nbytes == 2'd2) ? 2'd3 : wr_nbytes;
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = wr_en && !full;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; an entry is only read once level says it was written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{nbytes: nb_norm, data: wr_data};
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    send_data_d = send_data_q;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d     = ST_SEND;
          idx_d       = 2'd0;
          send_data_d = pick_byte(head, 2'd0);
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (Send_fin) begin
          if (idx_q == head.nbytes) begin
            pop     = 1'b1;
            idx_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d       = idx_q + 2'd1;
            send_data_d = pick_byte(head, idx_q + 2'd1);
            state_d     = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      send_data_q   <= 8'h00;
      sdata_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (wr_en && full) ovf_q <= 1'b1;
      state_q       <= state_d;
      idx_q         <= idx_d;
      send_data_q   <= send_data_d;
      sdata_valid_q <= (state_d == ST_SEND);
    end
  end

  assign level       = level_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q != ST_IDLE) || !empty;
  assign send_data   = send_data_q;
  assign Sdata_valid = sdata_valid_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: directed scenarios plus randomized bursts
// checked against a byte-stream model and a transmitter responder.
module tb_uart_tx_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [1:0]  wr_nbytes = '0;
  logic        full, empty, ovf, busy, Sdata_valid;
  logic [AW:0] level;
  logic [7:0]  send_data;
  logic        auto_fin = 1'b0;
  logic        man_fin = 1'b0;
  logic        Send_fin;

  bit          auto_en = 1'b0;
  int          fin_delay = 1;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cnt = 0;

  byte unsigned exp_q[$];
  bit           exp_first[$];
  byte unsigned rx_q[$];
  int           rx_cyc[$];
  int           fin_cyc[$];

  assign Send_fin = auto_fin | man_fin;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_data(wr_data), .wr_nbytes(wr_nbytes),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .busy(busy),
    .send_data(send_data), .Sdata_valid(Sdata_valid), .Send_fin(Send_fin)
  );

  always #5 CLK = ~CLK;

  // Transmitter model: logs every strobe and, when enabled, answers fin_delay cycles later.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      auto_fin = 1'b0;
      if (!RST_N) cnt = 0;
      else if (Sdata_valid) begin
        rx_q.push_back(send_data);
        rx_cyc.push_back(cyc);
        if (auto_en) cnt = fin_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          auto_fin = 1'b1;
          fin_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_push(input logic [31:0] d, input logic [1:0] nb);
    int n;
    n = (nb == 2'd0) ? 1 : (nb == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
`ifdef UART_TX_BUFFER_BIG_ENDIAN_EN
      exp_q.push_back(8'(d >> (8 * (n - 1 - k))));
`else
      exp_q.push_back(8'(d >> (8 * k)));
`endif
      exp_first.push_back(k == 0);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; man_fin = 1'b0; auto_en = 1'b0;
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();
    exp_q.delete(); exp_first.delete();
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #2;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (Sdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Sdata_valid); end
    n_checks++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", send_data); end
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || Sdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: busy=%b valid=%b want 0/0", busy, Sdata_valid); end
  endtask

  task automatic test_single_byte();
    int rb;
    do_reset();
    rb = rx_q.size();
    wr_en = 1'b1; wr_data = 32'h0000_0041; wr_nbytes = 2'd0;
    tick();
    wr_en = 1'b0; wr_data = $urandom;
    n_checks++; if (Sdata_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_strobe: got %b want 0", Sdata_valid); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level_push: got %0d want 1", level); end
    tick();
    n_checks++; if (Sdata_valid !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b want 1", Sdata_valid); end
    n_checks++; if (send_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", send_data); end
    tick();
    n_checks++; if (Sdata_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_pulse: got %b want 0", Sdata_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_wait: got %b want 1", busy); end
    repeat (19) tick();
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level_pop: got %0d want 0", level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    n_checks++; if (rx_q.size() - rb !== 1) begin n_fail++; $display("FAIL single_strobe_count: got %0d want 1", rx_q.size() - rb); end
  endtask

  task automatic test_word();
    int rb, fb, t;
    do_reset();
    rb = rx_q.size(); fb = fin_cyc.size();
    model_push(32'h4433_2211, 2'd3);
    auto_en = 1'b1; fin_delay = 10;
    wr_en = 1'b1; wr_data = 32'h4433_2211; wr_nbytes = 2'd3;
    tick();
    wr_en = 1'b0;
    t = 0;
    while (fin_cyc.size() - fb < 3 && t < 300) begin tick(); t++; end
    tick();
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL word_no_early_pop: got %0d want 1", level); end
    t = 0;
    while (fin_cyc.size() - fb < 4 && t < 300) begin tick(); t++; end
    n_checks++; if (t >= 300) begin n_fail++; $display("FAIL word_timeout: got %0d fins want 4", fin_cyc.size() - fb); end
    tick();
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL word_pop: got %0d want 0", level); end
    repeat (5) tick();
    n_checks++; if (rx_q.size() - rb !== 4) begin n_fail++; $display("FAIL word_strobe_count: got %0d want 4", rx_q.size() - rb); end
    for (int i = 0; i < exp_q.size() && rb + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rb+i] !== exp_q[i]) begin n_fail++; $display("FAIL word_byte%0d: got %h want %h", i, rx_q[rb+i], exp_q[i]); end
    end
    for (int i = 1; i < 4 && rb + i < rx_cyc.size() && fb + i - 1 < fin_cyc.size(); i++) begin
      n_checks++; if (rx_cyc[rb+i] - fin_cyc[fb+i-1] !== 1) begin n_fail++; $display("FAIL word_gap%0d: got %0d want 1", i, rx_cyc[rb+i] - fin_cyc[fb+i-1]); end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [31:0] pay [9];
    int rb, fb, t;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pay[i] = $urandom;
      wr_en = 1'b1; wr_data = pay[i]; wr_nbytes = 2'd0;
      tick();
    end
    wr_en = 1'b0;
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fill_level: got %0d want 8", level); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", ovf); end
    // Final fin of the head arrives together with a push while full.
    wr_en = 1'b1; wr_data = $urandom; wr_nbytes = 2'd0; man_fin = 1'b1;
    tick();
    wr_en = 1'b0; man_fin = 1'b0;
    n_checks++; if (level !== 4'd7) begin n_fail++; $display("FAIL simul_full_level: got %0d want 7", level); end
    n_checks++; if (full !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("FAIL simul_full_flags: full=%b ovf=%b want 0/1", full, ovf); end
    rb = rx_q.size(); fb = fin_cyc.size();
    n_checks++; if (rb < 1 || rx_q[rb-1] !== pay[0][7:0]) begin n_fail++; $display("FAIL fill_first_byte: got %h want %h", (rb > 0) ? rx_q[rb-1] : 8'hxx, pay[0][7:0]); end
    auto_en = 1'b1; fin_delay = 3;
    t = 0;
    while ((rx_q.size() - rb < 7 || busy) && t < 500) begin tick(); t++; end
    n_checks++; if (t >= 500) begin n_fail++; $display("FAIL fill_drain_timeout: got %0d bytes want 7", rx_q.size() - rb); end
    repeat (5) tick();
    n_checks++; if (rx_q.size() - rb !== 7) begin n_fail++; $display("FAIL fill_byte_count: got %0d want 7", rx_q.size() - rb); end
    for (int i = 0; i < 7 && rb + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rb+i] !== pay[i+1][7:0]) begin n_fail++; $display("FAIL fill_byte%0d: got %h want %h", i, rx_q[rb+i], pay[i+1][7:0]); end
    end
    for (int i = 1; i < 7 && rb + i < rx_cyc.size() && fb + i - 1 < fin_cyc.size(); i++) begin
      n_checks++; if (rx_cyc[rb+i] - fin_cyc[fb+i-1] !== 2) begin n_fail++; $display("FAIL entry_gap%0d: got %0d want 2", i, rx_cyc[rb+i] - fin_cyc[fb+i-1]); end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_simul_level3();
    logic [31:0] pay [4];
    int rb, t;
    do_reset();
    rb = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      pay[i] = $urandom;
      wr_en = 1'b1; wr_data = pay[i]; wr_nbytes = 2'd0;
      tick();
    end
    wr_en = 1'b0;
    tick();
    pay[3] = $urandom;
    wr_en = 1'b1; wr_data = pay[3]; wr_nbytes = 2'd0; man_fin = 1'b1;
    tick();
    wr_en = 1'b0; man_fin = 1'b0;
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL simul3_level: got %0d want 3", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL simul3_ovf: got %b want 0", ovf); end
    auto_en = 1'b1; fin_delay = 2;
    t = 0;
    while ((rx_q.size() - rb < 4 || busy) && t < 300) begin tick(); t++; end
    n_checks++; if (t >= 300) begin n_fail++; $display("FAIL simul3_timeout: got %0d bytes want 4", rx_q.size() - rb); end
    for (int i = 0; i < 4 && rb + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rb+i] !== pay[i][7:0]) begin n_fail++; $display("FAIL simul3_byte%0d: got %h want %h", i, rx_q[rb+i], pay[i][7:0]); end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_spurious_abort();
    int rb, rb2;
    do_reset();
    rb = rx_q.size();
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || Sdata_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL spurious_fin: busy=%b valid=%b level=%0d want 0/0/0", busy, Sdata_valid, level); end
    n_checks++; if (rx_q.size() !== rb) begin n_fail++; $display("FAIL spurious_strobe: got %0d strobes want 0", rx_q.size() - rb); end
    wr_en = 1'b1; wr_data = 32'h8765_4321; wr_nbytes = 2'd3;
    tick();
    wr_en = 1'b0;
    tick();
    n_checks++; if (Sdata_valid !== 1'b1) begin n_fail++; $display("FAIL spurious_then_push: got %b want 1", Sdata_valid); end
    tick();
    #1 RST_N = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL abort_fifo: level=%0d empty=%b full=%b want 0/1/0", level, empty, full); end
    n_checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL abort_flags: busy=%b ovf=%b want 0/0", busy, ovf); end
    n_checks++; if (Sdata_valid !== 1'b0 || send_data !== 8'h00) begin n_fail++; $display("FAIL abort_tx: valid=%b data=%h want 0/00", Sdata_valid, send_data); end
    rb2 = rx_q.size();
    tick();
    RST_N = 1'b1;
    repeat (10) tick();
    n_checks++; if (rx_q.size() !== rb2) begin n_fail++; $display("FAIL abort_no_strobe: got %0d strobes want 0", rx_q.size() - rb2); end
  endtask

  task automatic test_endianness();
    byte unsigned e0, e1;
    int rb, t;
`ifdef UART_TX_BUFFER_BIG_ENDIAN_EN
    e0 = 8'hAB; e1 = 8'hCD;
`else
    e0 = 8'hCD; e1 = 8'hAB;
`endif
    do_reset();
    rb = rx_q.size();
    auto_en = 1'b1; fin_delay = 2;
    wr_en = 1'b1; wr_data = 32'h0000_ABCD; wr_nbytes = 2'd1;
    tick();
    wr_en = 1'b0;
    t = 0;
    while ((rx_q.size() - rb < 2 || busy) && t < 100) begin tick(); t++; end
    n_checks++; if (rx_q.size() - rb !== 2) begin n_fail++; $display("FAIL endian_count: got %0d want 2", rx_q.size() - rb); end
    n_checks++; if (rx_q.size() > rb && rx_q[rb] !== e0) begin n_fail++; $display("FAIL endian_byte0: got %h want %h", rx_q[rb], e0); end
    n_checks++; if (rx_q.size() > rb + 1 && rx_q[rb+1] !== e1) begin n_fail++; $display("FAIL endian_byte1: got %h want %h", rx_q[rb+1], e1); end
    auto_en = 1'b0;
  endtask

  task automatic test_random();
    int rb, fb, t, n;
    logic [31:0] d;
    logic [1:0]  nb;
    do_reset();
    rb = rx_q.size(); fb = fin_cyc.size();
    auto_en = 1'b1; fin_delay = $urandom_range(1, 4);
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int e = 0; e < n; e++) begin
        repeat ($urandom_range(0, 3)) begin
          wr_data = $urandom; wr_nbytes = 2'($urandom);
          tick();
        end
        d = $urandom; nb = 2'($urandom_range(0, 3));
        model_push(d, nb);
        wr_en = 1'b1; wr_data = d; wr_nbytes = nb;
        tick();
        wr_en = 1'b0;
      end
      t = 0;
      while ((rx_q.size() - rb < exp_q.size() || busy) && t < 3000) begin tick(); t++; end
      n_checks++; if (t >= 3000) begin n_fail++; $display("FAIL random_timeout burst%0d: got %0d bytes want %0d", b, rx_q.size() - rb, exp_q.size()); end
    end
    repeat (5) tick();
    n_checks++; if (rx_q.size() - rb !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", rx_q.size() - rb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && rb + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rb+i] !== exp_q[i]) begin n_fail++; $display("FAIL random_byte%0d: got %h want %h", i, rx_q[rb+i], exp_q[i]); end
      if (i > 0 && rb + i < rx_cyc.size() && fb + i - 1 < fin_cyc.size()) begin
        n_checks++;
        if (exp_first[i] ? (rx_cyc[rb+i] - fin_cyc[fb+i-1] < 2) : (rx_cyc[rb+i] - fin_cyc[fb+i-1] !== 1)) begin
          n_fail++; $display("FAIL random_gap%0d: got %0d want %s", i, rx_cyc[rb+i] - fin_cyc[fb+i-1], exp_first[i] ? ">=2" : "1");
        end
      end
    end
    n_checks++; if (level !== 4'd0 || empty !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL random_end_state: level=%0d empty=%b ovf=%b want 0/1/0", level, empty, ovf); end
    auto_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_word();
    test_fill_overflow();
    test_simul_level3();
    test_spurious_abort();
    test_endianness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
